// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM read-port arbiter: port ids, response entries and
// the single in-flight read record.
package rom_arb_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_e;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
    logic  discard;
  } inflight_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Per-port response FIFO. Flush empties it and beats a same-cycle push;
// a same-cycle pop is still a completed transfer from the consumer's view.
module rsp_fifo
  import rom_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  rsp_t                       push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output rsp_t                       data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rsp_t          mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the registered-read instruction ROM between fetch (IF) and load (LD)
// with LD priority, an IF starvation guard and credit-based response buffering.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int RSP_DEPTH     = 2,
  parameter int LD_MAX_CONSEC = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [31:0] if_req_addr_i,
  input  logic        if_flush_i,
  output logic        if_rsp_valid_o,
  input  logic        if_rsp_ready_i,
  output logic [31:0] if_rsp_data_o,
  output logic        if_rsp_err_o,
  input  logic        ld_req_valid_i,
  output logic        ld_req_ready_o,
  input  logic [31:0] ld_req_addr_i,
  output logic        ld_rsp_valid_o,
  input  logic        ld_rsp_ready_i,
  output logic [31:0] ld_rsp_data_o,
  output logic        ld_rsp_err_o,
  output logic [31:0] rom_a_o,
  input  logic [31:0] rom_rd_i
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int FW = $clog2(LD_MAX_CONSEC + 1);

  inflight_t     inflight_q, inflight_d;
  logic [FW-1:0] fair_q, fair_d;
  logic [31:0]   hold_q;

  rsp_t          if_out, ld_out, rom_rsp;
  logic [CW-1:0] if_cnt, ld_cnt;
  logic          if_full, ld_full, if_empty, ld_empty;
  logic          if_pop, ld_pop, if_push, ld_push;
  logic          if_infl, ld_infl, elig_if, elig_ld;
  logic          grant_if, grant_ld;
  logic [CW:0]   if_occ, ld_occ;

  assign if_rsp_valid_o = ~if_empty;
  assign ld_rsp_valid_o = ~ld_empty;
  assign if_rsp_data_o  = if_out.data;
  assign if_rsp_err_o   = if_out.err;
  assign ld_rsp_data_o  = ld_out.data;
  assign ld_rsp_err_o   = ld_out.err;

  assign if_pop = if_rsp_valid_o & if_rsp_ready_i;
  assign ld_pop = ld_rsp_valid_o & ld_rsp_ready_i;

  // A discarded in-flight read will never land, so it holds no credit.
  assign if_infl = inflight_q.valid & ~inflight_q.discard & (inflight_q.port == PORT_IF);
  assign ld_infl = inflight_q.valid & ~inflight_q.discard & (inflight_q.port == PORT_LD);

  assign if_occ = {1'b0, if_cnt} + (CW+1)'(if_infl) - (CW+1)'(if_pop);
  assign ld_occ = {1'b0, ld_cnt} + (CW+1)'(ld_infl) - (CW+1)'(ld_pop);

  assign elig_if = rst_n_i & if_req_valid_i & (if_occ < (CW+1)'(RSP_DEPTH));
  assign elig_ld = rst_n_i & ld_req_valid_i & (ld_occ < (CW+1)'(RSP_DEPTH));

  always_comb begin
    grant_if = 1'b0;
    grant_ld = 1'b0;
    if (elig_if && elig_ld) begin
      if (fair_q == FW'(LD_MAX_CONSEC)) grant_if = 1'b1;
      else                              grant_ld = 1'b1;
    end else begin
      grant_if = elig_if;
      grant_ld = elig_ld;
    end
  end

  assign if_req_ready_o = grant_if;
  assign ld_req_ready_o = grant_ld;

  always_comb begin
    rom_a_o = hold_q;
    if (grant_if)      rom_a_o = if_req_addr_i;
    else if (grant_ld) rom_a_o = ld_req_addr_i;
  end

  always_comb begin
    inflight_d         = '0;
    inflight_d.valid   = grant_if | grant_ld;
    inflight_d.port    = grant_ld ? PORT_LD : PORT_IF;
    inflight_d.err     = is_misaligned(rom_a_o);
    inflight_d.discard = 1'b0;
  end

  always_comb begin
    fair_d = fair_q;
    if (!if_req_valid_i || grant_if) fair_d = '0;
    else if (grant_ld && elig_if)    fair_d = fair_q + FW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= '0;
      fair_q     <= '0;
      hold_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      fair_q     <= fair_d;
      hold_q     <= rom_a_o;
    end
  end

  // ROM data lands the cycle after the grant; an IF flush on that edge drops it.
  assign rom_rsp.data = rom_rd_i;
  assign rom_rsp.err  = inflight_q.err;
  assign if_push = inflight_q.valid & ~inflight_q.discard & (inflight_q.port == PORT_IF);
  assign ld_push = inflight_q.valid & ~inflight_q.discard & (inflight_q.port == PORT_LD);

  rsp_fifo #(.DEPTH(RSP_DEPTH)) u_if_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (if_push),
    .push_data_i (rom_rsp),
    .pop_i       (if_pop),
    .flush_i     (if_flush_i),
    .data_o      (if_out),
    .count_o     (if_cnt),
    .full_o      (if_full),
    .empty_o     (if_empty)
  );

  rsp_fifo #(.DEPTH(RSP_DEPTH)) u_ld_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (ld_push),
    .push_data_i (rom_rsp),
    .pop_i       (ld_pop),
    .flush_i     (1'b0),
    .data_o      (ld_out),
    .count_o     (ld_cnt),
    .full_o      (ld_full),
    .empty_o     (ld_empty)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized bench for rom_arbiter against a queue-based reference model,
// plus directed scenarios for latency, fairness, backpressure, flush and reset.
module tb_rom_arbiter;

  localparam int DEPTH   = 2;
  localparam int LD_MAX  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_rsp_valid, if_rsp_ready = 1'b0, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        ld_req_valid = 1'b0, ld_req_ready;
  logic [31:0] ld_req_addr = '0;
  logic        ld_rsp_valid, ld_rsp_ready = 1'b0, ld_rsp_err;
  logic [31:0] ld_rsp_data;
  logic [31:0] rom_a, rom_rd;

  logic [31:0] rom_mem [256];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [32:0] mq_if[$];
  logic [32:0] mq_ld[$];
  bit          m_inf_v;
  bit          m_inf_ld;
  logic [31:0] m_inf_addr;
  logic [31:0] m_hold;
  int          m_fair;
  logic [31:0] last_if_obs, last_ld_obs;
  bit          last_ld_err;
  int          if_pops;

  always #5 clk = ~clk;

  always @(posedge clk) rom_rd <= rom_mem[rom_a[9:2]];

  rom_arbiter #(.RSP_DEPTH(DEPTH), .LD_MAX_CONSEC(LD_MAX)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .if_req_valid_i (if_req_valid),
    .if_req_ready_o (if_req_ready),
    .if_req_addr_i  (if_req_addr),
    .if_flush_i     (if_flush),
    .if_rsp_valid_o (if_rsp_valid),
    .if_rsp_ready_i (if_rsp_ready),
    .if_rsp_data_o  (if_rsp_data),
    .if_rsp_err_o   (if_rsp_err),
    .ld_req_valid_i (ld_req_valid),
    .ld_req_ready_o (ld_req_ready),
    .ld_req_addr_i  (ld_req_addr),
    .ld_rsp_valid_o (ld_rsp_valid),
    .ld_rsp_ready_i (ld_rsp_ready),
    .ld_rsp_data_o  (ld_rsp_data),
    .ld_rsp_err_o   (ld_rsp_err),
    .rom_a_o        (rom_a),
    .rom_rd_i       (rom_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_if.delete();
    mq_ld.delete();
    m_inf_v = 0;
    m_inf_ld = 0;
    m_inf_addr = '0;
    m_hold = '0;
    m_fair = 0;
  endtask

  // Called mid-cycle: compare DUT outputs with the model, then advance the
  // model to what the next clock edge should produce.
  task automatic model_step();
    bit pop_if, pop_ld, e_if, e_ld, g_if, g_ld;
    int occ_if, occ_ld;
    logic [31:0] exp_a;
    logic [32:0] ent;

    check("if_rsp_valid", 32'(if_rsp_valid), 32'(mq_if.size() > 0));
    check("ld_rsp_valid", 32'(ld_rsp_valid), 32'(mq_ld.size() > 0));
    if (mq_if.size() > 0) begin
      check("if_rsp_data", if_rsp_data, mq_if[0][31:0]);
      check("if_rsp_err", 32'(if_rsp_err), 32'(mq_if[0][32]));
    end
    if (mq_ld.size() > 0) begin
      check("ld_rsp_data", ld_rsp_data, mq_ld[0][31:0]);
      check("ld_rsp_err", 32'(ld_rsp_err), 32'(mq_ld[0][32]));
    end

    pop_if = (mq_if.size() > 0) && if_rsp_ready;
    pop_ld = (mq_ld.size() > 0) && ld_rsp_ready;
    occ_if = mq_if.size() + ((m_inf_v && !m_inf_ld) ? 1 : 0) - (pop_if ? 1 : 0);
    occ_ld = mq_ld.size() + ((m_inf_v && m_inf_ld) ? 1 : 0) - (pop_ld ? 1 : 0);
    e_if = if_req_valid && (occ_if < DEPTH);
    e_ld = ld_req_valid && (occ_ld < DEPTH);
    g_ld = e_ld && (!e_if || (m_fair != LD_MAX));
    g_if = e_if && !g_ld;

    check("if_req_ready", 32'(if_req_ready), 32'(g_if));
    check("ld_req_ready", 32'(ld_req_ready), 32'(g_ld));
    check("one_ready", 32'(if_req_ready & ld_req_ready), 32'(0));
    exp_a = g_if ? if_req_addr : (g_ld ? ld_req_addr : m_hold);
    check("rom_a", rom_a, exp_a);

    if (if_rsp_valid && if_rsp_ready) begin
      last_if_obs = if_rsp_data;
      if_pops++;
    end
    if (ld_rsp_valid && ld_rsp_ready) begin
      last_ld_obs = ld_rsp_data;
      last_ld_err = ld_rsp_err;
    end

    if (pop_if) void'(mq_if.pop_front());
    if (pop_ld) void'(mq_ld.pop_front());
    if (if_flush) mq_if.delete();
    if (m_inf_v) begin
      ent = {(m_inf_addr[1:0] != 2'b00), rom_mem[m_inf_addr[9:2]]};
      if (m_inf_ld) mq_ld.push_back(ent);
      else if (!if_flush) mq_if.push_back(ent);
    end
    m_inf_v    = g_if || g_ld;
    m_inf_ld   = g_ld;
    m_inf_addr = exp_a;
    m_hold     = exp_a;
    if (!if_req_valid || g_if) m_fair = 0;
    else if (g_ld && e_if)     m_fair = m_fair + 1;
  endtask

  task automatic cyc(input logic iv, input logic [31:0] ia, input logic lv,
                     input logic [31:0] la, input logic ir, input logic lr,
                     input logic fl);
    @(posedge clk);
    #1;
    if_req_valid = iv;  if_req_addr = ia;
    ld_req_valid = lv;  ld_req_addr = la;
    if_rsp_ready = ir;  ld_rsp_ready = lr;
    if_flush = fl;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic rand_cycles(input int n, input int p_iv, input int p_lv,
                             input int p_rdy, input int p_fl);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 99) < p_iv, $urandom & 32'h3ff,
          $urandom_range(0, 99) < p_lv, $urandom & 32'h3ff,
          $urandom_range(0, 99) < p_rdy, $urandom_range(0, 99) < p_rdy,
          $urandom_range(0, 99) < p_fl);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rom_mem[2]   = 32'h0010f093;
    rom_mem[4]   = 32'hdead0004;
    rom_mem[8]   = 32'habcd0008;
    rom_mem[128] = 32'h5a5a0080;
    model_reset();
    if_pops = 0;

    repeat (3) @(posedge clk);
    #2;
    if_req_valid = 1'b1;
    #1;
    check("rst_if_ready", 32'(if_req_ready), 32'(0));
    check("rst_if_valid", 32'(if_rsp_valid), 32'(0));
    if_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch at 0x8: grant now, response two cycles later.
    cyc(1'b1, 32'h8, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("fetch_word2", last_if_obs, 32'h0010f093);

    // Both ports saturated: LD x4 then IF, repeating.
    for (int i = 0; i < 30; i++)
      cyc(1'b1, 32'(i * 4), 1'b1, 32'(i * 4 + 32'h100), 1'b1, 1'b1, 1'b0);
    idle(3);

    // IF backpressure: only two grants fit, then drain in order.
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'(i * 4), 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'(24 + i * 4), 1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Flush: 0x10 response is dropped, first IF response is word 8.
    if_pops = 0;
    cyc(1'b1, 32'h10, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h20, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    idle(3);
    check("flush_pops", 32'(if_pops), 32'(1));
    check("flush_word8", last_if_obs, 32'habcd0008);

    // Misaligned LD.
    cyc(1'b0, '0, 1'b1, 32'h202, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("ld_mis_data", last_ld_obs, 32'h5a5a0080);
    check("ld_mis_err", 32'(last_ld_err), 32'(1));

    rand_cycles(1500, 60, 50, 70, 3);
    rand_cycles(500, 90, 90, 30, 5);

    // Reset with one entry per FIFO and an LD read in flight.
    idle(4);
    cyc(1'b0, '0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 32'h48, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    if_req_valid = 1'b1;
    ld_req_valid = 1'b1;
    if_rsp_ready = 1'b0;
    ld_rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid_if_valid", 32'(if_rsp_valid), 32'(0));
    check("rstmid_ld_valid", 32'(ld_rsp_valid), 32'(0));
    check("rstmid_if_ready", 32'(if_req_ready), 32'(0));
    check("rstmid_ld_ready", 32'(ld_req_ready), 32'(0));
    model_reset();
    if_req_valid = 1'b0;
    ld_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstrel_rom_a", rom_a, 32'h0);
    idle(4);

    rand_cycles(400, 70, 70, 60, 4);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single read port of the instruction ROM between two requesters: instruction fetch (IF) and data load (LD, for constant tables placed in ROM).
- The ROM registers its read: an address presented in cycle N gives RD in cycle N+1.
- The arbiter tracks the in-flight read, buffers responses per port in small FIFOs, applies LD-priority arbitration with an IF starvation guard, and supports IF flush on redirect.

Parameters:
- RSP_DEPTH, 2: entries per port response FIFO; minimum 2.
- LD_MAX_CONSEC, 4: consecutive contested LD wins allowed before IF is forced to win; minimum 1.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- IF_REQ_VALID  in  1  fetch request.
- IF_REQ_READY  out  1  fetch request granted this cycle.
- IF_REQ_ADDR  in  32  byte address.
- IF_FLUSH  in  1  discard all pending/in-flight IF responses.
- IF_RSP_VALID  out  1  fetch response available.
- IF_RSP_READY  in  1  fetch response consumed.
- IF_RSP_DATA  out  32  instruction word.
- IF_RSP_ERR  out  1  request address was misaligned.
- LD_REQ_VALID, LD_REQ_READY, LD_REQ_ADDR, LD_RSP_VALID, LD_RSP_READY, LD_RSP_DATA, LD_RSP_ERR: same directions, widths and meaning for the load port.
- ROM_A  out  32  address to ROM.
- ROM_RD  in  32  ROM registered read data.

Behaviour:
- Reset: all FIFOs are emptied, in-flight valid is cleared, the fairness counter and the ROM_A hold register go to 0. All REQ_READY and RSP_VALID outputs are 0 while RST_N=0. Reset mid-transaction discards in-flight data, and no response is ever produced for it.
- Handshakes: a request transfers when REQ_VALID & REQ_READY; a response transfers when RSP_VALID & RSP_READY. REQ_READY is combinational from the arbitration decision, and at most one READY is high per cycle. RSP_DATA and RSP_ERR hold stable while RSP_VALID=1 and RSP_READY=0.
- Eligibility per port p: REQ_VALID_p and (count_p + inflight_p − pop_p) < RSP_DEPTH, where pop_p = RSP_VALID_p & RSP_READY_p. This credit rule guarantees every issued read has a FIFO slot.
- Arbitration:
  - Only one port eligible: that port wins.
  - Both eligible: LD wins unless fair_cnt == LD_MAX_CONSEC, in which case IF wins.
  - fair_cnt increments on each contested LD win.
  - fair_cnt clears on any IF grant, or in any cycle where IF_REQ_VALID=0.
- ROM address: in a grant cycle, ROM_A = the granted REQ_ADDR (combinational), and the hold register captures it. With no grant, ROM_A = hold register. ROM_A is forwarded unmodified.
- In-flight tracking:
  - The grant cycle registers inflight_valid, inflight_port, inflight_err = (addr[1:0] != 0), and inflight_discard = 0.
  - In cycle N+1, if inflight_valid and not discard, {ROM_RD, err} is pushed to the owning port FIFO.
- Latency:
  - Grant in cycle N, RSP_VALID in cycle N+2 (FIFO empty).
  - Sustained throughput: 1 response per cycle per winning port with RSP_READY held high.
- Misaligned address: the read is still performed and data is returned unmodified, with RSP_ERR=1.
- IF_FLUSH (sampled at the clock edge):
  - IF FIFO is emptied.
  - A same-cycle IF pop is still a valid transfer.
  - An IF read in flight at the flush edge gets inflight_discard=1, so its N+1 data is dropped.
  - An IF read granted in the same cycle as IF_FLUSH is new-target and is NOT discarded.
  - LD state is unaffected.
  - The credit rule treats a discarded in-flight read as occupying no slot.
- Simultaneous push and pop on one FIFO in the same cycle is legal; the count is unchanged.
- FIFO full with REQ_VALID=1: the port is ineligible and REQ_READY stays 0. The other port may still win.

Decomposition:
- Package rom_arb_pkg:
  - enum port_e {PORT_IF, PORT_LD}.
  - struct rsp_t {logic [31:0] data; logic err;}.
  - inflight_t struct {valid, port, err, discard}.
- Sub-module rsp_fifo: synchronous FIFO of rsp_t, depth RSP_DEPTH.
  - Ports: push, pop, flush, count, full, empty, async active-low reset.
  - Instantiated once per port; the LD instance has flush tied to 0.

Test Plan:
- Single IF request, addr 0x8, ROM word 2 = 0x0010f093, RSP_READY=1 → IF_REQ_READY in cycle 0, IF_RSP_VALID in cycle 2 with data 0x0010f093, ERR=0.
- IF and LD both valid continuously, all RSP_READY=1, LD_MAX_CONSEC=4 → grant pattern LD,LD,LD,LD,IF repeating. No cycle has both READYs high.
- IF streams addr 0x0,0x4,0x8… with IF_RSP_READY=0 → exactly 2 grants, then IF_REQ_READY=0. Raising RSP_READY resumes one response per cycle in address order.
- Grant IF at 0x10, assert IF_FLUSH next cycle together with a new IF request at 0x20 → the 0x10 response never appears, and the first IF response is word 8.
- LD request at addr 0x202 → LD_RSP_DATA = word 0x80, LD_RSP_ERR=1.
- Drop RST_N while an LD read is in flight and the FIFOs hold 1 entry each → all RSP_VALID=0 immediately. After release, no stale response appears and ROM_A=0.
